// File: rtl/tile_map_controller_if.sv
// Bus between game logic / level ROM / renderer and the tile-map controller.
// Parameters must match the ones given to tile_map_controller.
interface tile_map_controller_if #(
  parameter int unsigned ROWS         = 20,
  parameter int unsigned COLS         = 20,
  parameter int unsigned TILE_W       = 5,
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned SCORE_DIGITS = 2
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned AW = (NUM_LEVELS * ROWS * COLS > 1) ? $clog2(NUM_LEVELS * ROWS * COLS) : 1;
  localparam int unsigned LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int unsigned SW = 4 * SCORE_DIGITS;
  localparam int unsigned MW = ROWS * COLS * TILE_W;

  logic              level_req;
  logic              pickup_valid;
  logic [RW-1:0]     pickup_row;
  logic [CW-1:0]     pickup_col;
  logic [AW-1:0]     rom_addr;
  logic [TILE_W-1:0] rom_data;
  logic [MW-1:0]     map_out;
  logic [LW-1:0]     level_idx;
  logic              busy;
  logic              map_reset;
  logic [SW-1:0]     score_bcd;
  logic [SW-1:0]     hiscore_bcd;

  modport slave (
    input  level_req, pickup_valid, pickup_row, pickup_col, rom_data,
    output rom_addr, map_out, level_idx, busy, map_reset, score_bcd, hiscore_bcd
  );

  modport master (
    output level_req, pickup_valid, pickup_row, pickup_col, rom_data,
    input  rom_addr, map_out, level_idx, busy, map_reset, score_bcd, hiscore_bcd
  );
endinterface

// File: rtl/tile_map_controller.sv
// Tile-map manager: loads levels from a 1-cycle-latency ROM, animates coin/gem tiles, handles pickups
// and BCD score/high score. Define TILE_MAP_HUD_EN to draw high score and score into map row 0.
module tile_map_controller #(
  parameter int unsigned ROWS         = 20,
  parameter int unsigned COLS         = 20,
  parameter int unsigned TILE_W       = 5,
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned ANIM_DIV     = 25000000,
  parameter int unsigned SCORE_DIGITS = 2
) (
  input logic                  Clk,
  input logic                  reset,
  tile_map_controller_if.slave bus
);
  localparam int unsigned NT = ROWS * COLS;
  localparam int unsigned AW = (NUM_LEVELS * NT > 1) ? $clog2(NUM_LEVELS * NT) : 1;
  localparam int unsigned LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int unsigned PW = $clog2(ANIM_DIV);
  localparam int unsigned KW = $clog2(NT + 1);
  localparam int unsigned SW = 4 * SCORE_DIGITS;
  localparam int unsigned MW = NT * TILE_W;

  typedef logic [TILE_W-1:0] tile_t;
  localparam tile_t T_EMPTY  = tile_t'(0);
  localparam tile_t T_COIN0  = tile_t'(3);
  localparam tile_t T_COIN1  = tile_t'(4);
  localparam tile_t T_GEM0   = tile_t'(10);
  localparam tile_t T_GEM1   = tile_t'(11);
  localparam tile_t T_GEM2   = tile_t'(12);
  localparam tile_t T_GEM3   = tile_t'(13);
  localparam tile_t T_DIGIT0 = tile_t'(20);
  localparam logic [SW-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic {S_LOAD, S_RUN} state_t;
  state_t state_q, state_d;

  logic [MW-1:0] map_q, map_d;
  logic [KW-1:0] load_cnt;
  logic [AW-1:0] rom_addr_q;
  logic [LW-1:0] level_q;
  logic          busy_q;
  logic          map_reset_q;
  logic [SW-1:0] score_q, hiscore_q;
  logic [PW-1:0] presc_q;

  logic          load_done, tick, pick_ok, pick_hud;
  int unsigned   pick_idx;
  tile_t         pick_tile, pick_result;
  logic [SW-1:0] score_inc;
  logic [LW-1:0] level_next;
  logic [AW-1:0] rom_base, level_next_base;

  function automatic tile_t anim_step(input tile_t t);
    tile_t r;
    r = t;
    case (t)
      T_COIN0: r = T_COIN1;
      T_COIN1: r = T_COIN0;
      T_GEM0:  r = T_GEM1;
      T_GEM1:  r = T_GEM2;
      T_GEM2:  r = T_GEM3;
      T_GEM3:  r = T_GEM0;
      default: r = t;
    endcase
    return r;
  endfunction

  function automatic logic is_coin(input tile_t t);
    return (t == T_COIN0) || (t == T_COIN1);
  endfunction

  function automatic logic is_gem(input tile_t t);
    return (t >= T_GEM0) && (t <= T_GEM3);
  endfunction

  // Ripple-carry BCD increment that sticks at all-9s.
  function automatic logic [SW-1:0] bcd_inc_sat(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          carry;
    r     = s;
    carry = (s != ALL_NINES);
    for (int d = 0; d < int'(SCORE_DIGITS); d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_done) state_d = S_RUN;
      S_RUN:   if (bus.level_req) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Shared control decode for the datapath.
  always_comb begin
    load_done       = (state_q == S_LOAD) && (load_cnt == KW'(NT));
    tick            = (state_q == S_RUN) && (presc_q == PW'(ANIM_DIV - 1));
    level_next      = (level_q == LW'(NUM_LEVELS - 1)) ? '0 : level_q + LW'(1);
    rom_base        = AW'(32'(level_q) * NT);
    level_next_base = AW'(32'(level_next) * NT);
    pick_idx        = 0;
    if ((32'(bus.pickup_row) < ROWS) && (32'(bus.pickup_col) < COLS))
      pick_idx = 32'(bus.pickup_row) * COLS + 32'(bus.pickup_col);
    pick_tile   = map_q[pick_idx*TILE_W +: TILE_W];
    pick_result = is_coin(pick_tile) ? T_EMPTY : T_COIN0;
`ifdef TILE_MAP_HUD_EN
    pick_hud = (32'(bus.pickup_row) == 0) &&
               (((32'(bus.pickup_col) >= 1) && (32'(bus.pickup_col) <= SCORE_DIGITS)) ||
                ((32'(bus.pickup_col) >= COLS - 1 - SCORE_DIGITS) && (32'(bus.pickup_col) <= COLS - 2)));
`else
    pick_hud = 1'b0;
`endif
    pick_ok = (state_q == S_RUN) && bus.pickup_valid && !bus.level_req &&
              (32'(bus.pickup_row) < ROWS) && (32'(bus.pickup_col) < COLS) &&
              !pick_hud && (is_coin(pick_tile) || is_gem(pick_tile));
    score_inc = bcd_inc_sat(score_q);
  end

  // Next map: ROM write during load, animation/pickup/HUD during run.
  always_comb begin
    tile_t t;
    map_d = map_q;
    t     = T_EMPTY;
    if (state_q == S_LOAD) begin
      if (load_cnt != '0) map_d[(32'(load_cnt) - 1)*TILE_W +: TILE_W] = bus.rom_data;
    end else if (!bus.level_req) begin
      for (int unsigned i = 0; i < NT; i++) begin
        t = map_q[i*TILE_W +: TILE_W];
        if (tick) t = anim_step(t);
        if (pick_ok && (pick_idx == i)) t = pick_result;
        map_d[i*TILE_W +: TILE_W] = t;
      end
`ifdef TILE_MAP_HUD_EN
      for (int unsigned d = 0; d < SCORE_DIGITS; d++) begin
        map_d[(1 + d)*TILE_W +: TILE_W] =
          T_DIGIT0 + tile_t'(hiscore_q[4*(SCORE_DIGITS-1-d) +: 4]);
        map_d[(COLS - 1 - SCORE_DIGITS + d)*TILE_W +: TILE_W] =
          T_DIGIT0 + tile_t'(score_q[4*(SCORE_DIGITS-1-d) +: 4]);
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      map_q       <= '0;
      load_cnt    <= '0;
      rom_addr_q  <= '0;
      level_q     <= '0;
      busy_q      <= 1'b1;
      map_reset_q <= 1'b0;
      score_q     <= '0;
      hiscore_q   <= '0;
      presc_q     <= '0;
    end else begin
      map_q       <= map_d;
      map_reset_q <= 1'b0;
      if (state_q == S_LOAD) begin
        presc_q <= '0;
        if (load_done) begin
          load_cnt    <= '0;
          busy_q      <= 1'b0;
          map_reset_q <= 1'b1;
        end else begin
          load_cnt <= load_cnt + KW'(1);
          if (32'(load_cnt) + 1 < NT) rom_addr_q <= rom_base + AW'(load_cnt) + AW'(1);
        end
      end else if (bus.level_req) begin
        level_q    <= level_next;
        load_cnt   <= '0;
        rom_addr_q <= level_next_base;
        busy_q     <= 1'b1;
        presc_q    <= '0;
        if (level_next == '0) score_q <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (pick_ok) begin
          score_q <= score_inc;
          if (score_inc > hiscore_q) hiscore_q <= score_inc;
        end
      end
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.map_out     = map_q;
  assign bus.level_idx   = level_q;
  assign bus.busy        = busy_q;
  assign bus.map_reset   = map_reset_q;
  assign bus.score_bcd   = score_q;
  assign bus.hiscore_bcd = hiscore_q;
endmodule
